// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_serializer
// Description : UART transmit serializer. Pops bytes from a first-word-fall-
//               through TX FIFO, frames them (start, 5..8 data bits LSB-first,
//               optional parity, 1/1.5/2 stop bits) and shifts them out on
//               tx_o paced by an OVERSAMPLE x baud strobe. Supports line break
//               and reports busy / transmitter-empty status.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_serializer #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_pulse_i,
    input  logic       tx_fifo_empty_i,
    input  logic [7:0] tx_fifo_dout_i,
    output logic       tx_pop_o,
    input  logic [1:0] wls_i,
    input  logic       stb_i,
    input  logic       pen_i,
    input  logic       eps_i,
    input  logic       stick_i,
    input  logic       set_break_i,
    output logic       tx_o,
    output logic       tx_busy_o,
    output logic       temt_o
);

    // Tick counter must reach 2*OVERSAMPLE-1 for the longest stop period.
    localparam int TICK_W = $clog2(2 * OVERSAMPLE);

    localparam logic [TICK_W-1:0] c_tick_one   = TICK_W'(1);
    localparam logic [TICK_W-1:0] c_bit_last   = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] c_stop2_last = TICK_W'(2 * OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] c_stop15_last = TICK_W'((3 * OVERSAMPLE) / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // Registered frame state; configuration is captured per frame so that
    // LCR writes mid-frame only affect the next frame.
    state_t            r_state;
    logic [TICK_W-1:0] r_tick;
    logic [2:0]        r_bit_cnt;
    logic [7:0]        r_shift;
    logic              r_parity;
    logic [1:0]        r_wls;
    logic              r_stb;
    logic              r_pen;
    logic              r_tx;
    logic              r_temt;

    // Next-state values
    state_t            w_state_nxt;
    logic [TICK_W-1:0] w_tick_nxt;
    logic [2:0]        w_bit_cnt_nxt;
    logic [7:0]        w_shift_nxt;
    logic              w_parity_nxt;
    logic [1:0]        w_wls_nxt;
    logic              w_stb_nxt;
    logic              w_pen_nxt;
    logic              w_tx_nxt;
    logic              w_pop;

    logic [7:0]        w_mask;
    logic              w_xor;
    logic              w_par_in;
    logic [TICK_W-1:0] w_stop_last;
    logic [2:0]        w_word_last;
    logic              w_bit_end;

    // Parity of the incoming FIFO head, restricted to the selected word length;
    // computed at pop time so eps/stick need not be stored.
    always_comb begin
        case (wls_i)
            2'b00:   w_mask = 8'h1F;
            2'b01:   w_mask = 8'h3F;
            2'b10:   w_mask = 8'h7F;
            default: w_mask = 8'hFF;
        endcase
        w_xor    = ^(tx_fifo_dout_i & w_mask);
        w_par_in = stick_i ? ~eps_i : (eps_i ? w_xor : ~w_xor);
    end

    // Frame-length decode from the latched configuration.
    always_comb begin
        if (!r_stb)
            w_stop_last = c_bit_last;
        else if (r_wls == 2'b00)
            w_stop_last = c_stop15_last;
        else
            w_stop_last = c_stop2_last;
        w_word_last = 3'd4 + {1'b0, r_wls};
        w_bit_end   = (r_tick == c_bit_last);
    end

    // Next-state logic; nothing advances on cycles without a baud pulse.
    always_comb begin
        w_state_nxt   = r_state;
        w_tick_nxt    = r_tick;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_parity_nxt  = r_parity;
        w_wls_nxt     = r_wls;
        w_stb_nxt     = r_stb;
        w_pen_nxt     = r_pen;
        w_pop         = 1'b0;

        if (baud_pulse_i) begin
            case (r_state)
                S_IDLE: begin
                    w_pop = ~tx_fifo_empty_i;
                end
                S_START: begin
                    if (w_bit_end) begin
                        w_state_nxt   = S_DATA;
                        w_tick_nxt    = '0;
                        w_bit_cnt_nxt = 3'd0;
                    end else begin
                        w_tick_nxt = r_tick + c_tick_one;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        w_tick_nxt  = '0;
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                        if (r_bit_cnt == w_word_last)
                            w_state_nxt = r_pen ? S_PARITY : S_STOP;
                        else
                            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    end else begin
                        w_tick_nxt = r_tick + c_tick_one;
                    end
                end
                S_PARITY: begin
                    if (w_bit_end) begin
                        w_state_nxt = S_STOP;
                        w_tick_nxt  = '0;
                    end else begin
                        w_tick_nxt = r_tick + c_tick_one;
                    end
                end
                S_STOP: begin
                    if (r_tick == w_stop_last) begin
                        // Back-to-back frames: pop on the last stop tick so
                        // the next start bit follows with no idle gap.
                        w_pop       = ~tx_fifo_empty_i;
                        w_state_nxt = S_IDLE;
                        w_tick_nxt  = '0;
                    end else begin
                        w_tick_nxt = r_tick + c_tick_one;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_tick_nxt  = '0;
                end
            endcase

            if (w_pop) begin
                w_state_nxt   = S_START;
                w_tick_nxt    = '0;
                w_bit_cnt_nxt = 3'd0;
                w_shift_nxt   = tx_fifo_dout_i;
                w_parity_nxt  = w_par_in;
                w_wls_nxt     = wls_i;
                w_stb_nxt     = stb_i;
                w_pen_nxt     = pen_i;
            end
        end

        // Line level for the state being entered, so tx_o changes on the
        // same edge as the state.
        case (w_state_nxt)
            S_START:  w_tx_nxt = 1'b0;
            S_DATA:   w_tx_nxt = w_shift_nxt[0];
            S_PARITY: w_tx_nxt = w_parity_nxt;
            default:  w_tx_nxt = 1'b1;
        endcase
        if (set_break_i)
            w_tx_nxt = 1'b0;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_tick    <= '0;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'h00;
            r_parity  <= 1'b0;
            r_wls     <= 2'b00;
            r_stb     <= 1'b0;
            r_pen     <= 1'b0;
            r_tx      <= 1'b1;
            r_temt    <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_tick    <= w_tick_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_parity  <= w_parity_nxt;
            r_wls     <= w_wls_nxt;
            r_stb     <= w_stb_nxt;
            r_pen     <= w_pen_nxt;
            r_tx      <= w_tx_nxt;
            r_temt    <= tx_fifo_empty_i & (r_state == S_IDLE);
        end
    end

    // The pop strobe must be combinational so the FWFT head is captured in
    // the same cycle it is acknowledged.
    assign tx_pop_o  = w_pop & ~rst;
    assign tx_o      = r_tx;
    assign tx_busy_o = (r_state != S_IDLE);
    assign temt_o    = r_temt;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_serializer
// Description : Directed self-checking bench for uart_tx_serializer. Models
//               the FWFT TX FIFO, generates a baud strobe every 4 clk and
//               checks each frame bit at its mid-point plus frame timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_serializer;

    localparam int OS = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_pulse = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_dout = 8'h00;
    logic       tx_pop;
    logic [1:0] wls = 2'b11;
    logic       stb = 1'b0;
    logic       pen = 1'b0;
    logic       eps = 1'b0;
    logic       stick = 1'b0;
    logic       set_break = 1'b0;
    logic       tx;
    logic       tx_busy;
    logic       temt;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] fifo_q[$];
    int pulse_cnt = 0;
    int pop_cnt   = 0;
    int pop_last  = 0;
    int pop_prev  = 0;
    int bad_pop   = 0;
    int consumed  = 0;
    int div       = 0;
    int p0        = 0;
    int npop      = 0;

    uart_tx_serializer #(.OVERSAMPLE(OS)) dut (
        .clk             (clk),
        .rst             (rst),
        .baud_pulse_i    (baud_pulse),
        .tx_fifo_empty_i (fifo_empty),
        .tx_fifo_dout_i  (fifo_dout),
        .tx_pop_o        (tx_pop),
        .wls_i           (wls),
        .stb_i           (stb),
        .pen_i           (pen),
        .eps_i           (eps),
        .stick_i         (stick),
        .set_break_i     (set_break),
        .tx_o            (tx),
        .tx_busy_o       (tx_busy),
        .temt_o          (temt)
    );

    always #5 clk = ~clk;

    // Pre-edge sampling of strobes and pop bookkeeping.
    always @(posedge clk) begin
        if (baud_pulse) pulse_cnt <= pulse_cnt + 1;
        if (tx_pop) begin
            pop_cnt  <= pop_cnt + 1;
            pop_prev <= pop_last;
            pop_last <= pulse_cnt;
            if (fifo_empty) bad_pop <= bad_pop + 1;
        end
    end

    // FIFO model and baud strobe, updated just after the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            while (consumed < pop_cnt) begin
                if (fifo_q.size() > 0) void'(fifo_q.pop_front());
                consumed++;
            end
            fifo_empty = (fifo_q.size() == 0);
            fifo_dout  = fifo_empty ? 8'h00 : fifo_q[0];
            baud_pulse = (div == 3);
            div        = (div + 1) % 4;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_until(input int target);
        int n = 0;
        while (pulse_cnt < target && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("pulse_timeout", (pulse_cnt >= target), 1);
    endtask

    task automatic wait_pop(input int want);
        int n = 0;
        while (pop_cnt < want && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("pop_seen", (pop_cnt >= want), 1);
        p0 = pop_last;
    endtask

    // Wait until `off` pulses after the frame's pop pulse, then check tx.
    task automatic tx_at(input int off, input string tag, input logic exp);
        wait_until(p0 + 1 + off);
        check(tag, tx, exp);
    endtask

    function automatic logic [11:0] make_bits(input logic [7:0] d, input int wl,
                                               input bit par_en, input logic par);
        logic [11:0] b;
        b = '0;
        for (int i = 0; i < wl; i++) b[i+1] = d[i];
        if (par_en) b[wl+1] = par;
        return b;
    endfunction

    // Stop-bit level and exact length; `more` = next frame follows directly.
    task automatic check_tail(input string tag, input int nb, input int stop, input bit more);
        tx_at(nb*OS + stop/2, {tag, "_stop_mid"}, 1'b1);
        check({tag, "_temt_mid"}, temt, 0);
        wait_until(p0 + nb*OS + stop);
        check({tag, "_stop_last_tx"}, tx, 1);
        check({tag, "_stop_last_busy"}, tx_busy, 1);
        wait_until(p0 + 1 + nb*OS + stop);
        check({tag, "_end_busy"}, tx_busy, more);
        check({tag, "_end_tx"}, tx, !more);
    endtask

    task automatic check_frame(input string tag, input logic [11:0] bits, input int nb,
                               input int stop, input bit more);
        for (int i = 0; i < nb; i++) tx_at(i*OS + OS/2, {tag, "_bit"}, bits[i]);
        check_tail(tag, nb, stop, more);
    endtask

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
    endtask

    task automatic run_frame(input string tag, input logic [7:0] d, input int wl,
                             input bit par_en, input logic par, input int stop);
        @(negedge clk);
        push(d);
        npop++;
        wait_pop(npop);
        check_frame(tag, make_bits(d, wl, par_en, par), 1 + wl + int'(par_en), stop, 1'b0);
    endtask

    initial begin
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_temt", temt, 1);
        check("rst_pop", tx_pop, 0);

        // 8N1, 0x55
        wls = 2'b11; stb = 0; pen = 0;
        run_frame("t1_8n1", 8'h55, 8, 0, 1'b0, 16);
        repeat (2) @(negedge clk);
        check("t1_temt", temt, 1);
        check("t1_pops", pop_cnt, 1);

        // 7-bit parity variants on 0x41 (two ones in 7 bits)
        wls = 2'b10; pen = 1; eps = 1; stick = 0;
        run_frame("t2_even", 8'h41, 7, 1, 1'b0, 16);
        eps = 0;
        run_frame("t2_odd", 8'h41, 7, 1, 1'b1, 16);
        eps = 1; stick = 1;
        run_frame("t2_stk1", 8'h41, 7, 1, 1'b0, 16);
        eps = 0;
        run_frame("t2_stk0", 8'h41, 7, 1, 1'b1, 16);
        stick = 0; pen = 0;

        // Stop lengths: 1.5 bits with 5-bit words, 2 bits with 8-bit words
        wls = 2'b00; stb = 1;
        run_frame("t3_5b15", 8'h1F, 5, 0, 1'b0, 24);
        wls = 2'b11;
        run_frame("t3_8b2", 8'h80, 8, 0, 1'b0, 32);
        stb = 0;

        // Back-to-back frames
        @(negedge clk);
        push(8'hA5);
        push(8'h3C);
        npop++;
        wait_pop(npop);
        check_frame("t4_a5", make_bits(8'hA5, 8, 0, 1'b0), 9, 16, 1'b1);
        npop++;
        wait_pop(npop);
        check("t4_gap", pop_last - pop_prev, 160);
        check_frame("t4_3c", make_bits(8'h3C, 8, 0, 1'b0), 9, 16, 1'b0);

        // Break during DATA of 0xFF
        @(negedge clk);
        push(8'hFF);
        npop++;
        wait_pop(npop);
        tx_at(OS/2, "t5_start", 1'b0);
        tx_at(1*OS + OS/2, "t5_d0", 1'b1);
        wait_until(p0 + 1 + 2*OS + 4);
        set_break = 1;
        repeat (2) @(negedge clk);
        check("t5_brk_on", tx, 0);
        tx_at(3*OS + OS/2, "t5_brk_mid", 1'b0);
        check("t5_brk_busy", tx_busy, 1);
        wait_until(p0 + 1 + 4*OS + 4);
        set_break = 0;
        repeat (2) @(negedge clk);
        check("t5_resume", tx, 1);
        for (int i = 5; i < 9; i++) tx_at(i*OS + OS/2, "t5_bit", 1'b1);
        check_tail("t5", 9, 16, 1'b0);

        // Reset mid-DATA aborts frame; queued byte then sends cleanly
        @(negedge clk);
        push(8'hF0);
        push(8'h81);
        npop++;
        wait_pop(npop);
        tx_at(3*OS + OS/2, "t6_pre", 1'b0);
        rst = 1;
        @(negedge clk);
        check("t6_rst_tx", tx, 1);
        check("t6_rst_busy", tx_busy, 0);
        check("t6_rst_pops", pop_cnt, npop);
        rst = 0;
        npop++;
        wait_pop(npop);
        check_frame("t6_fresh", make_bits(8'h81, 8, 0, 1'b0), 9, 16, 1'b0);

        repeat (2) @(negedge clk);
        check("end_temt", temt, 1);
        check("pop_when_empty", bad_pop, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
